// File: rtl/dpi_flow_ctx_driver_pkg.sv
// Shared constants, FSM encoding and counter helper for the DPI flow context driver.
package dpi_flow_ctx_driver_pkg;

    localparam int unsigned NUM_FLOWS = 16;
    localparam int unsigned STATE_W   = 11;
    localparam int unsigned FLOW_W    = $clog2(NUM_FLOWS);
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned ERR_W     = CNT_W;
    localparam int unsigned OFF_W     = CNT_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTORE = 2'd1,
        STREAM  = 2'd2,
        SAVE    = 2'd3
    } drv_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dpi_ctx_ram.sv
// Per-flow matcher context store: flop array, combinational read, write port and clear port.
// A clear to the same slot as the write wins; a clear to the slot being read returns zero.
module dpi_ctx_ram #(
    parameter int unsigned NUM_FLOWS = 16,
    parameter int unsigned STATE_W   = 11,
    parameter int unsigned FLOW_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLOW_W-1:0]  rd_addr,
    output logic [STATE_W-1:0] rd_data,
    input  logic               wr_en,
    input  logic [FLOW_W-1:0]  wr_addr,
    input  logic [STATE_W-1:0] wr_data,
    input  logic               clr_en,
    input  logic [FLOW_W-1:0]  clr_addr
);

    logic [STATE_W-1:0] mem_q [NUM_FLOWS];

    // Slot update; the clear is applied last so it overrides a same-slot write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_FLOWS); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
            if (clr_en) begin
                mem_q[clr_addr] <= '0;
            end
        end
    end

    // Read with clear bypass so a same-cycle teardown never leaks stale state.
    assign rd_data = (clr_en && (clr_addr == rd_addr)) ? '0 : mem_q[rd_addr];

endmodule

// File: rtl/dpi_flow_ctx_driver.sv
// Time-multiplexes one DFA matcher across flows: restores the flow's state at SOP,
// streams the payload, saves the state after EOP and reports matches with byte offset.
// s_rdy, char_in(_vld) and state_in(_vld) are combinational: the matcher handshake
// and the SOP hold in IDLE need them within the same cycle.
module dpi_flow_ctx_driver #(
    parameter int unsigned NUM_FLOWS = dpi_flow_ctx_driver_pkg::NUM_FLOWS,
    parameter int unsigned STATE_W   = dpi_flow_ctx_driver_pkg::STATE_W,
    parameter int unsigned FLOW_W    = dpi_flow_ctx_driver_pkg::FLOW_W
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [7:0]                                 s_data,
    input  logic                                       s_vld,
    input  logic                                       s_sop,
    input  logic                                       s_eop,
    input  logic [FLOW_W-1:0]                          s_flow,
    output logic                                       s_rdy,
    output logic [7:0]                                 char_in,
    output logic                                       char_in_vld,
    output logic [STATE_W-1:0]                         state_in,
    output logic                                       state_in_vld,
    input  logic [STATE_W-1:0]                         state_out,
    input  logic                                       accept_out,
    input  logic                                       ctx_clr,
    input  logic [FLOW_W-1:0]                          ctx_clr_id,
    output logic                                       match_vld,
    output logic [FLOW_W-1:0]                          match_flow,
    output logic [dpi_flow_ctx_driver_pkg::OFF_W-1:0]  match_off,
    output logic [dpi_flow_ctx_driver_pkg::ERR_W-1:0]  err_cnt
);

    import dpi_flow_ctx_driver_pkg::*;

    drv_state_e          state_q, state_d;
    logic [FLOW_W-1:0]   flow_q;
    logic [OFF_W-1:0]    off_q;
    logic [STATE_W-1:0]  ctx_rd;
    logic                flow_ld;
    logic                off_clr;
    logic                off_inc;
    logic                err_inc;
    logic                ctx_we;

    dpi_ctx_ram #(
        .NUM_FLOWS (NUM_FLOWS),
        .STATE_W   (STATE_W),
        .FLOW_W    (FLOW_W)
    ) u_ctx_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (flow_q),
        .rd_data  (ctx_rd),
        .wr_en    (ctx_we),
        .wr_addr  (flow_q),
        .wr_data  (state_out),
        .clr_en   (ctx_clr),
        .clr_addr (ctx_clr_id)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, matcher interface and datapath strobes.
    always_comb begin
        state_d      = state_q;
        s_rdy        = 1'b0;
        char_in      = '0;
        char_in_vld  = 1'b0;
        state_in     = '0;
        state_in_vld = 1'b0;
        flow_ld      = 1'b0;
        off_clr      = 1'b0;
        off_inc      = 1'b0;
        err_inc      = 1'b0;
        ctx_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                // SOP beat is held back so it becomes the first STREAM byte.
                s_rdy = !(s_vld && s_sop);
                if (s_vld) begin
                    if (s_sop) begin
                        flow_ld = 1'b1;
                        state_d = RESTORE;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            RESTORE: begin
                state_in     = ctx_rd;
                state_in_vld = 1'b1;
                off_clr      = 1'b1;
                state_d      = STREAM;
            end
            STREAM: begin
                s_rdy       = 1'b1;
                char_in     = s_data;
                char_in_vld = s_vld;
                if (s_vld) begin
                    off_inc = 1'b1;
                    // Offset zero is the SOP byte itself; any later SOP is malformed.
                    if (s_sop && (off_q != '0)) begin
                        err_inc = 1'b1;
                    end
                    if (s_eop) begin
                        state_d = SAVE;
                    end
                end
            end
            SAVE: begin
                ctx_we  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!rst_n) begin
            s_rdy = 1'b0;
        end
    end

    // Flow latch, byte offset and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flow_q  <= '0;
            off_q   <= '0;
            err_cnt <= '0;
        end else begin
            if (flow_ld) begin
                flow_q <= s_flow;
            end
            if (off_clr) begin
                off_q <= '0;
            end else if (off_inc) begin
                off_q <= sat_inc(off_q);
            end
            if (err_inc) begin
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    // Match report, one cycle after the matching byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_vld  <= 1'b0;
            match_flow <= '0;
            match_off  <= '0;
        end else begin
            match_vld <= accept_out && char_in_vld;
            if (accept_out && char_in_vld) begin
                match_flow <= flow_q;
                match_off  <= off_q;
            end
        end
    end

endmodule

// File: tb/tb_dpi_flow_ctx_driver.sv
// Bench for dpi_flow_ctx_driver with an FTP "RETR %%" matcher and a per-flow stream model.
`timescale 1ns/1ps
module tb_dpi_flow_ctx_driver;

    localparam int unsigned NF = 16;
    localparam int unsigned SW = 11;
    localparam int unsigned FW = 4;
    localparam logic [55:0] PATS = "RETR %%";

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    s_data;
    logic          s_vld, s_sop, s_eop;
    logic [FW-1:0] s_flow;
    logic          s_rdy;
    logic [7:0]    char_in;
    logic          char_in_vld;
    logic [SW-1:0] state_in;
    logic          state_in_vld;
    logic [SW-1:0] state_out;
    logic          accept_out;
    logic          ctx_clr;
    logic [FW-1:0] ctx_clr_id;
    logic          match_vld;
    logic [FW-1:0] match_flow;
    logic [15:0]   match_off;
    logic [15:0]   err_cnt;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    logic [7:0]    hist [NF][$];
    int            err_exp = 0;
    int            nxt [NF];
    logic [FW-1:0] exp_flow [$];
    int            exp_off [$];
    logic [FW-1:0] obs_flow [$];
    logic [15:0]   obs_off [$];
    logic [7:0]    pkt_d [$];
    bit            pkt_sop [$];

    logic [SW-1:0] m_state;

    always #5 clk = ~clk;

    dpi_flow_ctx_driver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_data       (s_data),
        .s_vld        (s_vld),
        .s_sop        (s_sop),
        .s_eop        (s_eop),
        .s_flow       (s_flow),
        .s_rdy        (s_rdy),
        .char_in      (char_in),
        .char_in_vld  (char_in_vld),
        .state_in     (state_in),
        .state_in_vld (state_in_vld),
        .state_out    (state_out),
        .accept_out   (accept_out),
        .ctx_clr      (ctx_clr),
        .ctx_clr_id   (ctx_clr_id),
        .match_vld    (match_vld),
        .match_flow   (match_flow),
        .match_off    (match_off),
        .err_cnt      (err_cnt)
    );

    function automatic logic [7:0] pat_at(input int i);
        return PATS[8*(6-i) +: 8];
    endfunction

    // Matcher DFA: state = length of the longest pattern prefix ending here.
    function automatic int dfa_next(input int s_in, input logic [7:0] c);
        logic [7:0] b [8];
        int s;
        int n;
        bit ok;
        s = (s_in < 0 || s_in > 7) ? 0 : s_in;
        for (int i = 0; i < s; i++) b[i] = pat_at(i);
        b[s] = c;
        n = s + 1;
        for (int k = (n > 7) ? 7 : n; k > 0; k--) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) if (b[n-k+i] != pat_at(i)) ok = 1'b0;
            if (ok) return k;
        end
        return 0;
    endfunction

    // Matcher instance (lives outside the DUT).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_state <= '0;
        else if (state_in_vld) m_state <= state_in;
        else if (char_in_vld) m_state <= SW'(dfa_next(int'(m_state), char_in));
    end
    assign state_out  = m_state;
    assign accept_out = char_in_vld && (dfa_next(int'(m_state), char_in) == 7);

    function automatic int prefix_len(input logic [7:0] q [$]);
        int sz;
        bit ok;
        sz = q.size();
        for (int k = (sz > 7) ? 7 : sz; k > 0; k--) begin
            ok = 1'b1;
            for (int i = 0; i < k; i++) if (q[sz-k+i] != pat_at(i)) ok = 1'b0;
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Observe match reports and matcher interface exclusivity.
    always @(negedge clk) begin
        if (rst_n && match_vld) begin
            obs_flow.push_back(match_flow);
            obs_off.push_back(match_off);
        end
        if (char_in_vld && state_in_vld) chk("vld_excl", 32'd1, 32'd0);
    end

    task automatic drive_beat(input logic [7:0] d, input bit sop, input bit eop, input logic [FW-1:0] fl);
        bit acc;
        acc = 1'b0;
        s_vld = 1'b1; s_data = d; s_sop = sop; s_eop = eop; s_flow = fl;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(negedge clk);
            acc = s_rdy;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("beat_timeout", 32'd0, 32'd1);
        s_vld = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    endtask

    task automatic load_str(input string s);
        pkt_d.delete();
        pkt_sop.delete();
        for (int i = 0; i < s.len(); i++) begin
            pkt_d.push_back(s[i]);
            pkt_sop.push_back(1'b0);
        end
    endtask

    task automatic bump_err();
        if (err_exp < 65535) err_exp++;
    endtask

    task automatic idle_beat();
        drive_beat(8'($urandom), 1'b0, 1'b0, FW'($urandom));
        bump_err();
        chk("err_idle", 32'(err_cnt), 32'(err_exp));
    endtask

    task automatic clr_slot(input logic [FW-1:0] id);
        ctx_clr = 1'b1; ctx_clr_id = id;
        @(posedge clk); #1;
        ctx_clr = 1'b0;
        hist[id].delete();
    endtask

    task automatic cmp_matches();
        chk("match_cnt", 32'(obs_flow.size()), 32'(exp_flow.size()));
        while (obs_flow.size() > 0 && exp_flow.size() > 0) begin
            chk("match_flow", 32'(obs_flow.pop_front()), 32'(exp_flow.pop_front()));
            chk("match_off", 32'(obs_off.pop_front()), 32'(exp_off.pop_front()));
        end
        obs_flow.delete(); obs_off.delete();
        exp_flow.delete(); exp_off.delete();
    endtask

    // Send pkt_d on flow fl; optionally tear down the slot during RESTORE or SAVE.
    task automatic send_pkt(input logic [FW-1:0] fl, input bit clr_rst, input bit clr_sv, input bit gaps);
        logic [7:0] h [$];
        int n;
        int exp_rst;
        n = pkt_d.size();
        if (!clr_rst) h = hist[fl];
        exp_rst = prefix_len(h);
        for (int i = 0; i < n; i++) begin
            h.push_back(pkt_d[i]);
            if (h.size() > 7) void'(h.pop_front());
            if (h.size() == 7 && prefix_len(h) == 7) begin
                exp_flow.push_back(fl);
                exp_off.push_back(i);
            end
            if (i > 0 && pkt_sop[i]) bump_err();
        end
        if (clr_sv) hist[fl].delete();
        else hist[fl] = h;

        s_vld = 1'b1; s_sop = 1'b1; s_eop = (n == 1); s_data = pkt_d[0]; s_flow = fl;
        @(negedge clk);
        chk("sop_hold_rdy", 32'(s_rdy), 32'd0);
        @(posedge clk); #1;
        if (clr_rst) begin ctx_clr = 1'b1; ctx_clr_id = fl; end
        @(negedge clk);
        chk("restore_vld", 32'(state_in_vld), 32'd1);
        chk("restore_state", 32'(state_in), 32'(exp_rst));
        @(posedge clk); #1;
        ctx_clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            drive_beat(pkt_d[i], (i == 0) || pkt_sop[i], i == n - 1, (i == 0) ? fl : FW'($urandom));
        end
        if (clr_sv) begin ctx_clr = 1'b1; ctx_clr_id = fl; end
        @(negedge clk);
        chk("save_rdy", 32'(s_rdy), 32'd0);
        @(posedge clk); #1;
        ctx_clr = 1'b0;
        cmp_matches();
        chk("err_cnt", 32'(err_cnt), 32'(err_exp));
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NF); i++) begin
            hist[i].delete();
            nxt[i] = 0;
        end
        err_exp = 0;
        obs_flow.delete(); obs_off.delete();
        exp_flow.delete(); exp_off.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int start, len;
        logic [FW-1:0] fl;
        logic [7:0] b;
        rst_n = 1'b0; s_vld = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        s_data = '0; s_flow = '0; ctx_clr = 1'b0; ctx_clr_id = '0;
        model_reset();
        #1;
        chk("rst_rdy", 32'(s_rdy), 32'd0);
        chk("rst_match_vld", 32'(match_vld), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_state_in_vld", 32'(state_in_vld), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_rdy", 32'(s_rdy), 32'd1);
        @(posedge clk); #1;

        // Single packet match.
        load_str("RETR %%");
        send_pkt(4'd3, 1'b0, 1'b0, 1'b0);

        // Split across packets on one flow.
        clr_slot(4'd3);
        load_str("RETR"); send_pkt(4'd3, 1'b0, 1'b0, 1'b0);
        load_str(" %%");  send_pkt(4'd3, 1'b0, 1'b0, 1'b1);

        // Interleaved flows.
        clr_slot(4'd3); clr_slot(4'd5);
        load_str("RETR"); send_pkt(4'd3, 1'b0, 1'b0, 1'b0);
        load_str(" %%");  send_pkt(4'd5, 1'b0, 1'b0, 1'b0);
        load_str(" %%");  send_pkt(4'd3, 1'b0, 1'b0, 1'b0);

        // Teardown between packets, during SAVE and during RESTORE.
        clr_slot(4'd3);
        load_str("RETR"); send_pkt(4'd3, 1'b0, 1'b0, 1'b0);
        clr_slot(4'd3);
        load_str(" %%");  send_pkt(4'd3, 1'b0, 1'b0, 1'b0);
        load_str("RETR"); send_pkt(4'd3, 1'b0, 1'b1, 1'b0);
        load_str(" %%");  send_pkt(4'd3, 1'b0, 1'b0, 1'b0);
        load_str("RETR"); send_pkt(4'd3, 1'b0, 1'b0, 1'b0);
        load_str(" %%");  send_pkt(4'd3, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a packet on a flow with saved context.
        load_str("RETR"); send_pkt(4'd3, 1'b0, 1'b0, 1'b0);
        s_vld = 1'b1; s_sop = 1'b1; s_eop = 1'b0; s_data = "R"; s_flow = 4'd3;
        repeat (3) begin @(posedge clk); #1; end
        s_sop = 1'b0; s_data = "E";
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(s_rdy), 32'd0);
        chk("mid_rst_civ", 32'(char_in_vld), 32'd0);
        chk("mid_rst_char", 32'(char_in), 32'd0);
        chk("mid_rst_siv", 32'(state_in_vld), 32'd0);
        chk("mid_rst_state_in", 32'(state_in), 32'd0);
        chk("mid_rst_mvld", 32'(match_vld), 32'd0);
        chk("mid_rst_mflow", 32'(match_flow), 32'd0);
        chk("mid_rst_moff", 32'(match_off), 32'd0);
        chk("mid_rst_err", 32'(err_cnt), 32'd0);
        s_vld = 1'b0;
        model_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_str(" %%"); send_pkt(4'd3, 1'b0, 1'b0, 1'b0);

        // Protocol errors: stray beats in IDLE and an inner SOP.
        idle_beat();
        idle_beat();
        load_str("RETR %%");
        pkt_sop[3] = 1'b1;
        send_pkt(4'd7, 1'b0, 1'b0, 1'b0);
        chk("err_three", 32'(err_cnt), 32'd3);

        // Randomized traffic over a handful of flows.
        for (int p = 0; p < 80; p++) begin
            fl = FW'($urandom_range(0, 3) * 5);
            if ($urandom_range(0, 5) == 0) idle_beat();
            if ($urandom_range(0, 7) == 0) clr_slot(FW'($urandom_range(0, 15)));
            len = $urandom_range(1, 9);
            start = ($urandom_range(0, 1) == 1) ? nxt[fl] : $urandom_range(0, 6);
            pkt_d.delete(); pkt_sop.delete();
            for (int j = 0; j < len; j++) begin
                b = pat_at((start + j) % 7);
                if ($urandom_range(0, 9) == 0) b = 8'($urandom_range(65, 90));
                pkt_d.push_back(b);
                pkt_sop.push_back(j > 0 && $urandom_range(0, 15) == 0);
            end
            nxt[fl] = (start + len) % 7;
            send_pkt(fl, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dpi_flow_ctx_driver.md
DPI_FLOW_CTX_DRIVER -- requirements
Module: dpi_flow_ctx_driver

Interface
REQ-001 Parameter NUM_FLOWS, default 16, number of per-flow context slots (power of two).
REQ-002 Parameter STATE_W, default 11, width of the matcher DFA state.
REQ-003 Parameter FLOW_W, default 4, equal to log2(NUM_FLOWS).
REQ-004 clk  input  1  single clock; all logic is rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_data  input  8  packet payload byte.
REQ-007 s_vld  input  1  s_data/s_sop/s_eop/s_flow valid.
REQ-008 s_sop  input  1  first byte of packet.
REQ-009 s_eop  input  1  last byte of packet; may coincide with s_sop.
REQ-010 s_flow  input  FLOW_W  flow index; sampled on the SOP beat only.
REQ-011 s_rdy  output  1  byte accepted when s_vld && s_rdy.
REQ-012 char_in  output  8  byte to matcher.
REQ-013 char_in_vld  output  1  matcher consumes char_in this cycle.
REQ-014 state_in  output  STATE_W  context state loaded into the matcher.
REQ-015 state_in_vld  output  1  matcher overwrites its state this cycle.
REQ-016 state_out  input  STATE_W  matcher current state, registered in the matcher.
REQ-017 accept_out  input  1  matcher match, combinational with char_in_vld.
REQ-018 ctx_clr  input  1  one-cycle pulse: zero context slot ctx_clr_id (connection teardown).
REQ-019 ctx_clr_id  input  FLOW_W  slot to clear.
REQ-020 match_vld  output  1  one-cycle match report.
REQ-021 match_flow  output  FLOW_W  flow of the reported match.
REQ-022 match_off  output  16  byte offset in the packet of the matching byte, SOP byte = 0.
REQ-023 err_cnt  output  16  count of dropped or malformed beats, saturating.

Function
REQ-024 FSM states: IDLE, RESTORE, STREAM, SAVE.
REQ-025 IDLE: s_rdy=1; a beat with s_sop=0 is dropped and err_cnt increments; a beat with s_vld && s_sop is not consumed (s_rdy=0 that cycle); s_flow is latched and the FSM enters RESTORE.
REQ-026 RESTORE, one cycle: state_in = ctx[flow], state_in_vld = 1, s_rdy = 0; next state is STREAM.
REQ-027 STREAM: s_rdy = 1; char_in = s_data; char_in_vld = s_vld; the offset counter starts at 0 and increments per consumed byte, saturating at 0xFFFF.
REQ-028 STREAM, a consumed beat with s_sop=1 after the first byte is treated as data, and err_cnt increments.
REQ-029 STREAM, a consumed beat with s_eop=1 moves the FSM to SAVE.
REQ-030 SAVE, one cycle: s_rdy = 0; ctx[flow] is written with state_out, which already reflects the EOP byte; next state is IDLE.
REQ-031 accept_out && char_in_vld registers match_vld = 1 one cycle later, with match_flow = the latched flow and match_off = the offset of that byte.
REQ-032 Multiple matches in one packet are each reported.
REQ-033 char_in_vld and state_in_vld are never high in the same cycle.
REQ-034 ctx_clr is honoured in any FSM state and writes ctx[ctx_clr_id] = 0.
REQ-035 If ctx_clr targets the slot being written in SAVE in the same cycle, the clear wins.
REQ-036 If ctx_clr targets the slot being read in RESTORE in the same cycle, state_in = 0.
REQ-037 err_cnt saturates at 0xFFFF.
REQ-038 The back-to-back packet cost is 2 idle cycles per packet (RESTORE + SAVE) plus the SOP detect cycle.

Reset
REQ-039 On rst_n low, asynchronously: FSM = IDLE; all ctx slots = 0; offset counter = 0; err_cnt = 0.
REQ-040 On rst_n low: match_vld = 0, match_flow = 0, match_off = 0.
REQ-041 On rst_n low: char_in_vld = 0, state_in_vld = 0, state_in = 0, char_in = 0; s_rdy = 0 while reset is asserted.
REQ-042 A reset during STREAM discards the partial packet without saving it; the matcher's own reset brings it to state 0.

Structure
REQ-043 A shared package holds STATE_W, FLOW_W, NUM_FLOWS, the FSM state enum and the err_cnt width.
REQ-044 The context store is one sub-module, dpi_ctx_ram: NUM_FLOWS x STATE_W flops, one combinational read port, one write port and a clear port with clear priority.
REQ-045 The matcher is instantiated outside this block, with char_in/state_in/state_out/accept_out connected one-to-one.

Verification
REQ-046 Bench: connect the FTP RETR matcher, flow 3, single packet "RETR %%" -> exactly one match_vld, with match_flow=3 and match_off=6.
REQ-047 Split packets on flow 3: "RETR" then " %%" -> no match in packet 1; ctx[3] is nonzero after SAVE; packet 2 gives match_off=2.
REQ-048 Interleaving: flow 3 "RETR", flow 5 " %%", flow 3 " %%" -> no match on flow 5; match on flow 3 at match_off=2.
REQ-049 ctx_clr on id 3 between the two packets of REQ-047 -> no match; ctx_clr in the same cycle as SAVE on 3 -> ctx[3]=0.
REQ-050 Protocol errors: two non-SOP beats in IDLE, then a packet with an inner s_sop -> err_cnt=3 and the packet is still processed.
REQ-051 Assert rst_n low mid-STREAM -> all outputs are 0 immediately; after release, the first SOP goes through RESTORE with state_in=0.
